// File: rtl/riscv_pkg.sv
// Shared definitions for the core's memory-side blocks: arbiter state encoding
// and default address/data widths.
package riscv_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between fetch (IF) and data (MEM) accesses.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
//
// state    | meaning
// ST_IDLE  | no access outstanding, arbitrate pending requests
// ST_IBUSY | fetch access on the memory port, waiting for mem_ready
// ST_DBUSY | data access on the memory port, waiting for mem_ready
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int DW           = DW_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic idle, if_pend, d_pend, grant_if, grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_valid_q   <= if_valid_d;
            d_valid_q    <= d_valid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // A side whose valid is pulsing still holds its old request; it must not be re-granted.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        if_pend  = if_req & ~if_valid_q;
        d_pend   = d_req & ~d_valid_q;
        grant_if = idle & if_pend & (~d_pend | (starve_cnt_q == CNT_MAX));
        grant_d  = idle & d_pend & ~grant_if;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if)     state_d = ST_IBUSY;
                else if (grant_d) state_d = ST_DBUSY;
            end
            ST_IBUSY, ST_DBUSY: begin
                if (mem_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_valid_d   = 1'b0;
        d_valid_d    = 1'b0;
        starve_cnt_d = starve_cnt_q;

        if (grant_if) begin
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
        end else if (grant_d) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
        end

        if ((state_q == ST_IBUSY) && mem_ready) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
        end
        if ((state_q == ST_DBUSY) && mem_ready) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
        end

        if (grant_if || (idle && !if_pend)) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a random
// phase, all compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, stall_if, stall_mem, mem_req, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data) and the transaction it carries.
    int          m_own, m_age, m_cnt;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    logic        m_we, m_ifv, m_dv;

    // Memory responder controls: fixed latency (-1 random), idle glitch mode, fixed read data.
    int          mem_lat = -1;
    int          spurious = 0;
    bit          fixed_en = 0;
    logic [31:0] fixed_rdata = '0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_age = 0; m_cnt = 0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_dr = '0;
        m_we = 1'b0; m_ifv = 1'b0; m_dv = 1'b0;
    endtask

    task automatic model_next();
        logic ip, dp;
        if (rst) begin
            model_reset();
        end else begin
            ip = if_req && !m_ifv;
            dp = d_req && !m_dv;
            m_ifv = 1'b0;
            m_dv  = 1'b0;
            if (m_own == 0) begin
                m_age = 0;
                if (ip && (!dp || m_cnt == LIMIT)) begin
                    m_own = 1; m_addr = if_addr; m_we = 1'b0; m_cnt = 0;
                end else if (dp) begin
                    m_own = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                    m_cnt = ip ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
                end else begin
                    m_cnt = 0;
                end
            end else if (mem_ready) begin
                if (m_own == 1) begin m_ifr = mem_rdata; m_ifv = 1'b1; end
                else            begin m_dr  = mem_rdata; m_dv  = 1'b1; end
                m_own = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    // One clock: drive memory response, check combinational stalls, advance model, check registers.
    task automatic clk_step();
        if (m_own != 0)
            mem_ready = (mem_lat < 0) ? ($urandom_range(0, 2) == 0) : (m_age == mem_lat);
        else
            mem_ready = (spurious == 2) || ((spurious == 1) && ($urandom_range(0, 3) == 0));
        mem_rdata = fixed_en ? fixed_rdata : $urandom();
        #1;
        check("stall_if", stall_if, if_req & ~m_ifv);
        check("stall_mem", stall_mem, d_req & ~m_dv);
        model_next();
        @(posedge clk);
        #1;
        check("mem_req", mem_req, m_own != 0);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("if_valid", if_valid, m_ifv);
        check("d_valid", d_valid, m_dv);
        if (m_ifv) check("if_rdata", if_rdata, m_ifr);
        if (m_dv && !m_we) check("d_rdata", d_rdata, m_dr);
    endtask

    task automatic wait_if_valid(int bound);
        int n = 0;
        while (!m_ifv && n < bound) begin clk_step(); n++; end
        check("wait_if_valid", if_valid, 1);
    endtask

    task automatic wait_d_valid(int bound);
        int n = 0;
        while (!m_dv && n < bound) begin clk_step(); n++; end
        check("wait_d_valid", d_valid, 1);
    endtask

    task automatic rand_reqs();
        if (m_ifv || !if_req) begin
            if_req  = ($urandom_range(0, 1) == 1);
            if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (m_dv || !d_req) begin
            d_req   = ($urandom_range(0, 1) == 1);
            d_we    = ($urandom_range(0, 1) == 1);
            d_addr  = $urandom() & 32'hFFFF_FFFC;
            d_wdata = $urandom();
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        clk_step();
        clk_step();
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        clk_step();

        // Fetch only, ready two cycles after mem_req rises.
        mem_lat = 2; fixed_en = 1; fixed_rdata = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h40;
        clk_step();
        check("fetch_mem_addr", mem_addr, 32'h40);
        check("fetch_mem_we", mem_we, 0);
        wait_if_valid(20);
        check("fetch_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        clk_step();

        // Simultaneous fetch and store: data first, fetch right after.
        fixed_en = 0; mem_lat = 1;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        clk_step();
        check("both_mem_we", mem_we, 1);
        check("both_mem_addr", mem_addr, 32'h100);
        check("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_d_valid(20);
        d_req = 1'b0;
        clk_step();
        check("both_fetch_addr", mem_addr, 32'h80);
        check("both_fetch_we", mem_we, 0);
        wait_if_valid(20);
        if_req = 1'b0;
        clk_step();

        // Continuous data traffic with a held fetch request.
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            if (m_dv) d_addr = d_addr + 32'd4;
            if (m_ifv) if_addr = if_addr + 32'd4;
            clk_step();
        end
        if_req = 1'b0; d_req = 1'b0;
        clk_step(); clk_step();

        // Zero-wait memory, back-to-back fetches.
        mem_lat = 0;
        if_req = 1'b1; if_addr = 32'h300;
        for (int i = 0; i < 18; i++) begin
            if (m_ifv) if_addr = if_addr + 32'd4;
            clk_step();
        end
        if_req = 1'b0;
        clk_step();

        // Reset while a load is outstanding.
        mem_lat = 6;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        clk_step();
        clk_step();
        check("rst_mid_busy", mem_req, 1);
        rst = 1'b1; d_req = 1'b0;
        clk_step();
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_d_valid", d_valid, 0);
        check("rst_mid_d_rdata", d_rdata, 32'h0);
        check("rst_mid_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) clk_step();

        // mem_ready asserted while idle must do nothing.
        spurious = 2;
        for (int i = 0; i < 5; i++) clk_step();
        spurious = 0;
        clk_step();

        // Random traffic with random latency, idle glitches and occasional reset.
        mem_lat = -1; spurious = 1;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            rand_reqs();
            clk_step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
